// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-cache requests from the EX|MEM latch, stalls the
// pipeline until the cache answers, tracks the LL/SC link and produces the MEM|WB latch.
package mem_stage_pkg;

    typedef struct packed {
        logic        DataRead;
        logic        DataWrite;
        logic        StoreConditional;
        logic        LinkedLoad;
        logic        Jal;
        logic        ImmToReg;
        logic        Halt;
        logic        RegWr;
        logic [4:0]  wsel;
        logic [31:0] aluout;
        logic [31:0] rdat2;
        logic [31:0] pc_plus;
        logic [15:0] imm;
    } exmem_t;

    typedef struct packed {
        logic [31:0] dmemload;
        logic [31:0] wdat;
        logic [31:0] pc_plus;
        logic        Halt;
        logic        RegWr;
        logic        DataRead;
        logic [4:0]  wsel;
    } memwb_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HALTED
    } state_t;

endpackage

module mem_stage_ctrl
    import mem_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  exmem_t      exmem_in,
    input  logic        dhit,
    input  logic [31:0] dload,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        mem_stall,
    output memwb_t      memwb_out
);

    state_t      state;
    state_t      state_next;
    state_t      cur_state;

    logic        link_valid;
    logic [31:0] link_addr;

    logic        hold_ren;
    logic        hold_wen;
    logic [31:0] hold_addr;
    logic [31:0] hold_store;

    logic        mem_op;
    logic        sc_fail;
    logic        capture;
    logic        advance;
    logic        done_access;
    logic        ll_set;
    logic        write_clear;
    logic        inv_clear;
    memwb_t      wb_next;
    memwb_t      halt_bubble;

    assign mem_op  = exmem_in.DataRead | exmem_in.DataWrite;
    assign sc_fail = exmem_in.StoreConditional &
                     !(link_valid && (link_addr == exmem_in.aluout));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        // While reset is held the request path behaves as in IDLE.
        cur_state   = nRST ? state : IDLE;
        state_next  = cur_state;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = 32'h0;
        dstore      = 32'h0;
        mem_stall   = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        done_access = 1'b0;

        case (cur_state)
            IDLE: begin
                if (mem_op && !sc_fail) begin
                    dREN   = exmem_in.DataRead;
                    dWEN   = exmem_in.DataWrite & ~exmem_in.DataRead;
                    daddr  = exmem_in.aluout;
                    dstore = exmem_in.rdat2;
                    if (dhit) begin
                        done_access = 1'b1;
                    end else begin
                        mem_stall  = 1'b1;
                        capture    = 1'b1;
                        state_next = ACCESS;
                    end
                end
                if (!mem_stall) begin
                    advance = 1'b1;
                    if (exmem_in.Halt) state_next = HALTED;
                end
            end
            ACCESS: begin
                dREN   = hold_ren;
                dWEN   = hold_wen;
                daddr  = hold_addr;
                dstore = hold_store;
                if (dhit) begin
                    done_access = 1'b1;
                    advance     = 1'b1;
                    state_next  = exmem_in.Halt ? HALTED : IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            HALTED: begin
            end
            default: state_next = IDLE;
        endcase
    end

    // Next MEM|WB contents for a retiring instruction.
    always_comb begin
        wb_next          = '0;
        wb_next.dmemload = exmem_in.DataRead ? dload : 32'h0;
        wb_next.Halt     = exmem_in.Halt;
        wb_next.RegWr    = exmem_in.RegWr | exmem_in.StoreConditional;
        wb_next.DataRead = exmem_in.DataRead;
        wb_next.wsel     = exmem_in.wsel;
        wb_next.pc_plus  = exmem_in.pc_plus;
        // An SC that issued its write succeeded, even if the link is snooped away mid-access.
        if (exmem_in.StoreConditional)
            wb_next.wdat = {31'h0, done_access};
        else if (exmem_in.Jal)
            wb_next.wdat = exmem_in.pc_plus;
        else if (exmem_in.ImmToReg)
            wb_next.wdat = {exmem_in.imm, 16'h0};
        else
            wb_next.wdat = exmem_in.aluout;
    end

    always_comb begin
        halt_bubble      = '0;
        halt_bubble.Halt = 1'b1;
    end

    assign ll_set      = done_access & dREN & exmem_in.LinkedLoad;
    assign write_clear = done_access & dWEN & link_valid & (daddr == link_addr);
    assign inv_clear   = ccinv & link_valid & (ccsnoopaddr == link_addr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            memwb_out  <= '0;
            link_valid <= 1'b0;
            link_addr  <= 32'h0;
            hold_ren   <= 1'b0;
            hold_wen   <= 1'b0;
            hold_addr  <= 32'h0;
            hold_store <= 32'h0;
        end else begin
            state <= state_next;

            if (capture) begin
                hold_ren   <= dREN;
                hold_wen   <= dWEN;
                hold_addr  <= daddr;
                hold_store <= dstore;
            end

            if (advance)
                memwb_out <= wb_next;
            else if (state == HALTED)
                memwb_out <= halt_bubble;
            else
                memwb_out <= '0;

            // A completing LL re-arms the link even if the same address is invalidated now.
            if (ll_set) begin
                link_valid <= 1'b1;
                link_addr  <= daddr;
            end else if (write_clear || inv_clear) begin
                link_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, LL/SC link tracking, halt and reset.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    exmem_t      exmem_in;
    logic        dhit;
    logic [31:0] dload;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        mem_stall;
    memwb_t      memwb_out;

    int vectors    = 0;
    int miscompares = 0;

    mem_stage_ctrl dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .exmem_in   (exmem_in),
        .dhit       (dhit),
        .dload      (dload),
        .ccinv      (ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .mem_stall  (mem_stall),
        .memwb_out  (memwb_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkwb(input string tag, input memwb_t exp);
        vectors++;
        assert (memwb_out === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, memwb_out, exp);
        end
    endtask

    // Request-side outputs in one call.
    task automatic check_req(input string tag, input logic ren, input logic wen,
                             input logic stall);
        check32({tag, ".dREN"}, {31'h0, dREN}, {31'h0, ren});
        check32({tag, ".dWEN"}, {31'h0, dWEN}, {31'h0, wen});
        check32({tag, ".stall"}, {31'h0, mem_stall}, {31'h0, stall});
    endtask

    function automatic exmem_t nop();
        exmem_t e = '0;
        e.pc_plus = 32'h10;
        return e;
    endfunction

    function automatic exmem_t lw(input logic [31:0] a);
        exmem_t e = nop();
        e.DataRead = 1'b1;
        e.RegWr    = 1'b1;
        e.wsel     = 5'd2;
        e.aluout   = a;
        return e;
    endfunction

    function automatic exmem_t ll(input logic [31:0] a);
        exmem_t e = lw(a);
        e.LinkedLoad = 1'b1;
        return e;
    endfunction

    function automatic exmem_t sw(input logic [31:0] a, input logic [31:0] d);
        exmem_t e = nop();
        e.DataWrite = 1'b1;
        e.aluout    = a;
        e.rdat2     = d;
        return e;
    endfunction

    function automatic exmem_t sc(input logic [31:0] a, input logic [31:0] d);
        exmem_t e = sw(a, d);
        e.StoreConditional = 1'b1;
        e.RegWr            = 1'b1;
        e.wsel             = 5'd2;
        return e;
    endfunction

    function automatic memwb_t wb(input logic [31:0] ld, input logic [31:0] wd,
                                  input logic [31:0] pc, input logic h, input logic rw,
                                  input logic dr, input logic [4:0] ws);
        memwb_t m;
        m.dmemload = ld;
        m.wdat     = wd;
        m.pc_plus  = pc;
        m.Halt     = h;
        m.RegWr    = rw;
        m.DataRead = dr;
        m.wsel     = ws;
        return m;
    endfunction

    initial begin
        exmem_t e;
        nRST        = 1'b0;
        exmem_in    = nop();
        dhit        = 1'b0;
        dload       = 32'h0;
        ccinv       = 1'b0;
        ccsnoopaddr = 32'h0;
        tick();
        tick();
        checkwb("reset.memwb", '0);
        check_req("reset", 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;

        // Load that waits three cycles for the cache.
        exmem_in = lw(32'h100);
        dload    = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_req("lw.wait", 1'b1, 1'b0, 1'b1);
            check32("lw.daddr", daddr, 32'h100);
            tick();
            checkwb("lw.bubble", '0);
        end
        dhit = 1'b1;
        #1;
        check_req("lw.hit", 1'b1, 1'b0, 1'b0);
        tick();
        checkwb("lw.result", wb(32'hDEADBEEF, 32'h100, 32'h10, 1'b0, 1'b1, 1'b1, 5'd2));
        dhit = 1'b0;

        // Store that stalls one cycle; the request must come from the captured copy.
        exmem_in = sw(32'h300, 32'hCAFE);
        #1;
        check_req("sw.issue", 1'b0, 1'b1, 1'b1);
        check32("sw.dstore", dstore, 32'hCAFE);
        tick();
        e = exmem_in;
        e.rdat2  = 32'h1111;
        exmem_in = e;
        #1;
        check32("sw.hold_dstore", dstore, 32'hCAFE);
        check32("sw.hold_daddr", daddr, 32'h300);
        dhit = 1'b1;
        #1;
        check_req("sw.hit", 1'b0, 1'b1, 1'b0);
        tick();
        checkwb("sw.result", wb(32'h0, 32'h300, 32'h10, 1'b0, 1'b0, 1'b0, 5'd0));

        // LL then SC to the same address succeeds and consumes the link.
        exmem_in = ll(32'h200);
        dload    = 32'h77;
        #1;
        check_req("ll.issue", 1'b1, 1'b0, 1'b0);
        tick();
        checkwb("ll.result", wb(32'h77, 32'h200, 32'h10, 1'b0, 1'b1, 1'b1, 5'd2));
        exmem_in = sc(32'h200, 32'h5);
        dhit     = 1'b0;
        #1;
        check_req("sc.issue", 1'b0, 1'b1, 1'b1);
        check32("sc.daddr", daddr, 32'h200);
        check32("sc.dstore", dstore, 32'h5);
        tick();
        dhit = 1'b1;
        tick();
        checkwb("sc.success", wb(32'h0, 32'h1, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));
        dhit = 1'b0;
        #1;
        check_req("sc.again", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("sc.again_fail", wb(32'h0, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // Snoop invalidate of the linked address breaks the SC.
        exmem_in = ll(32'h200);
        dhit     = 1'b1;
        tick();
        exmem_in    = nop();
        dhit        = 1'b0;
        ccinv       = 1'b1;
        ccsnoopaddr = 32'h200;
        tick();
        ccinv    = 1'b0;
        exmem_in = sc(32'h200, 32'h9);
        #1;
        check_req("inv.sc", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("inv.sc_fail", wb(32'h0, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // Invalidate coinciding with LL completion: the new link wins.
        exmem_in = ll(32'h200);
        dhit     = 1'b1;
        ccinv    = 1'b1;
        tick();
        ccinv    = 1'b0;
        exmem_in = sc(32'h200, 32'h7);
        #1;
        check_req("llwins.sc", 1'b0, 1'b1, 1'b0);
        tick();
        checkwb("llwins.result", wb(32'h0, 32'h1, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // Invalidate of an unrelated address leaves the link intact.
        exmem_in = ll(32'h200);
        tick();
        exmem_in    = nop();
        ccinv       = 1'b1;
        ccsnoopaddr = 32'h204;
        tick();
        ccinv    = 1'b0;
        exmem_in = sc(32'h200, 32'h8);
        #1;
        check_req("otherinv.sc", 1'b0, 1'b1, 1'b0);
        tick();
        checkwb("otherinv.result", wb(32'h0, 32'h1, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // A plain store to the linked address kills the link.
        exmem_in = ll(32'h240);
        tick();
        exmem_in = sw(32'h240, 32'h3);
        tick();
        exmem_in = sc(32'h240, 32'h4);
        #1;
        check_req("swclr.sc", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("swclr.result", wb(32'h0, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // Write-back value selection without a memory request.
        e         = nop();
        e.Jal     = 1'b1;
        e.RegWr   = 1'b1;
        e.wsel    = 5'd31;
        e.pc_plus = 32'h44;
        e.aluout  = 32'h99;
        exmem_in  = e;
        dhit      = 1'b0;
        #1;
        check_req("jal", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("jal.result", wb(32'h0, 32'h44, 32'h44, 1'b0, 1'b1, 1'b0, 5'd31));
        e          = nop();
        e.ImmToReg = 1'b1;
        e.RegWr    = 1'b1;
        e.wsel     = 5'd3;
        e.imm      = 16'h1234;
        e.aluout   = 32'h55;
        exmem_in   = e;
        #1;
        check_req("lui", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("lui.result", wb(32'h0, 32'h12340000, 32'h10, 1'b0, 1'b1, 1'b0, 5'd3));

        // Reset in the middle of an outstanding access drops it and clears the link.
        exmem_in = ll(32'h200);
        dhit     = 1'b1;
        tick();
        exmem_in = lw(32'h180);
        dhit     = 1'b0;
        tick();
        check_req("rstacc.wait", 1'b1, 1'b0, 1'b1);
        nRST     = 1'b0;
        exmem_in = nop();
        tick();
        check_req("rstacc.after", 1'b0, 1'b0, 1'b0);
        checkwb("rstacc.memwb", '0);
        nRST     = 1'b1;
        exmem_in = sc(32'h200, 32'h6);
        dhit     = 1'b1;
        #1;
        check_req("rstacc.sc", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("rstacc.sc_fail", wb(32'h0, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 5'd2));

        // Halt freezes the stage until reset.
        e         = '0;
        e.Halt    = 1'b1;
        exmem_in  = e;
        dhit      = 1'b0;
        tick();
        checkwb("halt.latch", wb(32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0));
        exmem_in = lw(32'h100);
        #1;
        check_req("halt.lw", 1'b0, 1'b0, 1'b0);
        tick();
        checkwb("halt.hold1", wb(32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0));
        tick();
        check_req("halt.lw2", 1'b0, 1'b0, 1'b0);
        checkwb("halt.hold2", wb(32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; nRST  in  1  reset, synchronous, active-low.
REQ-002 SHALL have exmem_in  in  exmem_t  EX|MEM latch contents, held stable by upstream while mem_stall=1.
REQ-003 SHALL have dhit  in  1  cache completes current request this cycle; dload  in  32  read data, valid with dhit.
REQ-004 SHALL have ccinv  in  1  coherence invalidate; ccsnoopaddr  in  32  invalidated address.
REQ-005 SHALL have dREN  out  1; dWEN  out  1; daddr  out  32; dstore  out  32: the data-cache request.
REQ-006 SHALL have mem_stall  out  1  freeze IF..MEM; memwb_out  out  memwb_t  registered MEM|WB latch.

Function
REQ-007 SHALL implement states IDLE, ACCESS, HALTED.
REQ-008 mem_op SHALL be DataRead|DataWrite; sc_fail SHALL be StoreConditional & !(link_valid & link_addr==aluout).
REQ-009 IDLE with mem_op & !sc_fail: dREN=DataRead, dWEN=DataWrite, daddr=aluout, dstore=rdat2, combinationally.
REQ-010 IDLE request with dhit same cycle: no stall, result latched into memwb_out at the edge, stay IDLE.
REQ-011 IDLE request without dhit: mem_stall=1, capture daddr/dstore/op into hold regs, go ACCESS.
REQ-012 ACCESS: request driven from hold regs, not exmem_in; mem_stall=1 until dhit; on dhit mem_stall=0, result latched, go IDLE.
REQ-013 sc_fail: no request issued, no stall, result wdat=0 with RegWr=1.
REQ-014 SC success: write issued; on completion wdat=1, link_valid cleared.
REQ-015 LL (DataRead & LinkedLoad) completion: link_valid=1, link_addr=aluout.
REQ-016 ccinv & link_valid & ccsnoopaddr==link_addr: clear link_valid; same-cycle LL completion to same address: LL set wins.
REQ-017 Any completed DataWrite (incl. SC) to link_addr SHALL clear link_valid.
REQ-018 wdat priority: StoreConditional -> 0/1; Jal -> pc_plus; ImmToReg -> {imm,16'h0}; else aluout.
REQ-019 memwb_out on non-stalled edge: dmemload=dload (0 if not DataRead), Halt, RegWr, DataRead, wsel, pc_plus from exmem_in; wdat per REQ-018.
REQ-020 memwb_out on stalled edge SHALL be a bubble: all-zero.
REQ-021 exmem_in.Halt on non-stalled edge: latch Halt into memwb_out, go HALTED.
REQ-022 HALTED: dREN=dWEN=0, mem_stall=0, memwb_out bubble with Halt=1 held, exit only by reset.
REQ-023 dREN and dWEN SHALL never be 1 simultaneously; both 0 outside REQ-009/012.

Reset
REQ-024 nRST=0 at an edge: state=IDLE, memwb_out=0, link_valid=0, link_addr=0, hold regs=0.
REQ-025 Reset during ACCESS: request dropped; dREN=dWEN=0, mem_stall=0 from the cycle after reset edge.
REQ-026 While nRST=0, outputs SHALL be driven as in IDLE with memwb_out=0.

Verification
REQ-027 LW aluout=0x100, dhit after 3 cycles, dload=0xDEADBEEF -> mem_stall=1 for 3 cycles, then memwb_out.dmemload=0xDEADBEEF, RegWr=1.
REQ-028 LL 0x200, then SC 0x200 rdat2=0x5 -> dWEN=1, daddr=0x200, dstore=0x5, memwb_out.wdat=1, link cleared.
REQ-029 LL 0x200, ccinv ccsnoopaddr=0x200, SC 0x200 -> no dWEN, no stall, wdat=0.
REQ-030 Jal pc_plus=0x44 / ImmToReg imm=0x1234 -> wdat=0x44 / 0x12340000, no request.
REQ-031 nRST low during ACCESS -> next cycle dREN=dWEN=0, mem_stall=0, memwb_out=0, link_valid=0.
REQ-032 Halt with no mem_op -> memwb_out.Halt=1 next edge; later exmem_in LW -> dREN stays 0.
